mo_hpos_counter_bank: RTL and testbench
=======================================

# mo_hpos_counter_bank

Parametrised bank of motion-object horizontal line-buffer address counters for the sprite pipeline. It generalises the fixed two-counter horizontal control to CHANNELS independent counters of width AW. Each counter supports load-from-shifter, clear and free-running count on the pixel clock enable. New over the previous generation: a per-channel write window that flags the WIN pixels following a load, and an optional horizontal-flip (down-count) mode. It sits between the motion-object shift register and the line-buffer RAM write/read ports.

## Interface
- CHANNELS, 2, number of independent counters; e.g. 2 for ping-pong line buffers
- AW, 8, counter/address width
- SRW, 16, shifter word width; load value is SR[SRW-1 -: AW]; SRW >= AW
- WIN, 16, write-window length in ce cycles, 1..255
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- ce  in  1  pixel clock enable; all state changes only on clk edges with ce=1
- sr  in  SRW  motion-object shifter word
- ld_n  in  CHANNELS  per-channel active-low load
- cl_n  in  CHANNELS  per-channel active-low clear
- flip  in  CHANNELS  per-channel horizontal flip; count direction select
- addr  out  CHANNELS*AW  flat counter bus; channel k at [k*AW +: AW]
- wr_active  out  CHANNELS  high while the channel's write window is open
- win_left  out  CHANNELS*8  remaining window cycles, channel k at [k*8 +: 8]

## Operation
- Channels are fully independent; the same rules apply to each channel k.
- Priority per ce cycle: load > clear > count.
- Load (ld_n[k]=0): addr_k <= sr[SRW-1 -: AW]; win_left_k <= WIN; wr_active_k <= 1. A load during an open window restarts it.
- Clear (cl_n[k]=0, ld_n[k]=1): addr_k <= 0; win_left_k <= 0; wr_active_k <= 0. Clear aborts an open window.
- Count (both inactive): addr_k <= addr_k + 1, or addr_k - 1 when flip[k]=1 and the flip feature is compiled in. Arithmetic is modulo 2^AW: 2^AW-1 wraps to 0 up, 0 wraps to 2^AW-1 down.
- Window: when win_left_k > 0, each counting ce decrements win_left_k. wr_active_k <= (win_left_k > 1), so the window covers exactly WIN counting cycles after the load cycle.
- flip is sampled every ce cycle; a mid-window change takes effect on the next count.
- ce=0: all state holds; ld_n/cl_n are ignored.

## Timing
- All outputs are registered; there is no combinational input-to-output path.
- Latency: one clk edge with ce=1 from ld_n/cl_n/sr to addr/wr_active.
- After load at edge E: addr = loaded value, wr_active=1 from E. wr_active falls at the WIN-th subsequent counting edge; addr has then advanced WIN steps.
- Reset (rst_n=0, asynchronous): addr=0, wr_active=0, win_left=0 on every channel immediately, regardless of clk/ce. Release is synchronous to the next clk edge. Reset mid-window discards the window.

## Configuration
- MO_HFLIP_EN defined: the flip input selects the down-count direction per channel as above.
- MO_HFLIP_EN undefined: the flip input is ignored, and counters always increment, identical to the previous-generation behaviour. The window logic is unchanged either way.

## Test plan
- Reset: hold rst_n=0 with clk running -> all addr=0, wr_active=0, win_left=0; assert rst_n=0 mid-count, asynchronously -> outputs are 0 before the next clk edge.
- Load/count: CHANNELS=2, sr=16'hF300, ld_n=2'b10 for one ce -> ch0 addr=8'hF3, wr_active[0]=1. After 13 counting ce cycles addr=8'h00 (wrap). wr_active[0] falls after the 16th count at addr=8'h03; ch1 is unaffected.
- Priority: ld_n[1]=0 and cl_n[1]=0 together with sr=16'h4000 -> addr1=8'h40, window open. Next cycle cl_n[1]=0 alone -> addr1=0, wr_active[1]=0.
- Flip (MO_HFLIP_EN): flip[0]=1, load 8'h02, count 3 -> addr 01, 00, FF; rebuilt without the macro, the same stimulus -> 03, 04, 05.
- ce gating/restart: ce=0 for 10 clocks mid-window -> addr and win_left frozen. Reload at win_left=3 -> win_left=16, addr takes the new value.

Source files
------------

// File: rtl/mo_hpos_counter_bank.sv
// Bank of CHANNELS motion-object line-buffer address counters with per-channel write window.
// Define MO_HFLIP_EN to let flip[k] select down-counting; otherwise counters always increment.
module mo_hpos_counter_bank #(
  parameter int CHANNELS = 2,
  parameter int AW       = 8,
  parameter int SRW      = 16,
  parameter int WIN      = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   ce,
  input  logic [SRW-1:0]         sr,
  input  logic [CHANNELS-1:0]    ld_n,
  input  logic [CHANNELS-1:0]    cl_n,
  input  logic [CHANNELS-1:0]    flip,
  output logic [CHANNELS*AW-1:0] addr,
  output logic [CHANNELS-1:0]    wr_active,
  output logic [CHANNELS*8-1:0]  win_left
);

`ifdef MO_HFLIP_EN
  localparam bit HFLIP = 1'b1;
`else
  localparam bit HFLIP = 1'b0;
`endif

  localparam logic [7:0] WIN_LD = 8'(WIN);

  logic [AW-1:0]       addr_q [CHANNELS];
  logic [7:0]          win_q  [CHANNELS];
  logic [CHANNELS-1:0] act_q;
  logic [CHANNELS-1:0] down;
  logic [AW-1:0]       ld_val;

  // Masking with HFLIP keeps flip referenced but inert when the feature is compiled out.
  always_comb begin
    down   = flip & {CHANNELS{HFLIP}};
    ld_val = sr[SRW-1 -: AW];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned k = 0; k < CHANNELS; k++) begin
        addr_q[k] <= '0;
        win_q[k]  <= '0;
      end
      act_q <= '0;
    end else if (ce) begin
      for (int unsigned k = 0; k < CHANNELS; k++) begin
        if (!ld_n[k]) begin
          addr_q[k] <= ld_val;
          win_q[k]  <= WIN_LD;
          act_q[k]  <= 1'b1;
        end else if (!cl_n[k]) begin
          addr_q[k] <= '0;
          win_q[k]  <= '0;
          act_q[k]  <= 1'b0;
        end else begin
          addr_q[k] <= down[k] ? addr_q[k] - AW'(1) : addr_q[k] + AW'(1);
          if (win_q[k] != 8'd0)
            win_q[k] <= win_q[k] - 8'd1;
          act_q[k] <= (win_q[k] > 8'd1);
        end
      end
    end
  end

  always_comb begin
    addr     = '0;
    win_left = '0;
    for (int unsigned k = 0; k < CHANNELS; k++) begin
      addr[k*AW +: AW]  = addr_q[k];
      win_left[k*8 +: 8] = win_q[k];
    end
    wr_active = act_q;
  end

endmodule

// File: tb/tb_mo_hpos_counter_bank.sv
// Directed self-checking bench for mo_hpos_counter_bank (CHANNELS=2, AW=8, SRW=16, WIN=16).
module tb_mo_hpos_counter_bank;

  logic        clk;
  logic        rst_n;
  logic        ce;
  logic [15:0] sr;
  logic [1:0]  ld_n;
  logic [1:0]  cl_n;
  logic [1:0]  flip;
  logic [15:0] addr;
  logic [1:0]  wr_active;
  logic [15:0] win_left;

  int n_checks = 0;
  int n_fail   = 0;

  mo_hpos_counter_bank #(
    .CHANNELS(2),
    .AW(8),
    .SRW(16),
    .WIN(16)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .ce(ce),
    .sr(sr),
    .ld_n(ld_n),
    .cl_n(cl_n),
    .flip(flip),
    .addr(addr),
    .wr_active(wr_active),
    .win_left(win_left)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0; ce = 1'b1; sr = 16'h0000; ld_n = 2'b11; cl_n = 2'b11; flip = 2'b00;
    step(3);
    n_checks++; if (addr !== 16'h0000) begin n_fail++; $display("FAIL reset_addr got=%h exp=%h", addr, 16'h0000); end
    n_checks++; if (wr_active !== 2'b00) begin n_fail++; $display("FAIL reset_wr got=%b exp=%b", wr_active, 2'b00); end
    n_checks++; if (win_left !== 16'h0000) begin n_fail++; $display("FAIL reset_win got=%h exp=%h", win_left, 16'h0000); end
    rst_n = 1'b1;
    sr = 16'h5500; ld_n = 2'b10;
    step(1);
    ld_n = 2'b11;
    step(2);
    n_checks++; if (addr[7:0] !== 8'h57) begin n_fail++; $display("FAIL pre_async_addr got=%h exp=%h", addr[7:0], 8'h57); end
    #2 rst_n = 1'b0;
    #1;
    n_checks++; if (addr !== 16'h0000) begin n_fail++; $display("FAIL async_addr got=%h exp=%h", addr, 16'h0000); end
    n_checks++; if (wr_active !== 2'b00) begin n_fail++; $display("FAIL async_wr got=%b exp=%b", wr_active, 2'b00); end
    n_checks++; if (win_left !== 16'h0000) begin n_fail++; $display("FAIL async_win got=%h exp=%h", win_left, 16'h0000); end
    step(1);
    rst_n = 1'b1;
  endtask

  task automatic test_load_count;
    sr = 16'hF300; ld_n = 2'b10; cl_n = 2'b01; flip = 2'b00;
    step(1);
    n_checks++; if (addr[7:0] !== 8'hF3) begin n_fail++; $display("FAIL load_addr got=%h exp=%h", addr[7:0], 8'hF3); end
    n_checks++; if (wr_active[0] !== 1'b1) begin n_fail++; $display("FAIL load_wr got=%b exp=1", wr_active[0]); end
    n_checks++; if (win_left[7:0] !== 8'd16) begin n_fail++; $display("FAIL load_win got=%0d exp=16", win_left[7:0]); end
    ld_n = 2'b11;
    step(13);
    n_checks++; if (addr[7:0] !== 8'h00) begin n_fail++; $display("FAIL wrap_addr got=%h exp=%h", addr[7:0], 8'h00); end
    n_checks++; if (win_left[7:0] !== 8'd3) begin n_fail++; $display("FAIL wrap_win got=%0d exp=3", win_left[7:0]); end
    step(2);
    n_checks++; if (wr_active[0] !== 1'b1) begin n_fail++; $display("FAIL count15_wr got=%b exp=1", wr_active[0]); end
    n_checks++; if (addr[7:0] !== 8'h02) begin n_fail++; $display("FAIL count15_addr got=%h exp=%h", addr[7:0], 8'h02); end
    step(1);
    n_checks++; if (wr_active[0] !== 1'b0) begin n_fail++; $display("FAIL count16_wr got=%b exp=0", wr_active[0]); end
    n_checks++; if (addr[7:0] !== 8'h03) begin n_fail++; $display("FAIL count16_addr got=%h exp=%h", addr[7:0], 8'h03); end
    n_checks++; if (win_left[7:0] !== 8'd0) begin n_fail++; $display("FAIL count16_win got=%0d exp=0", win_left[7:0]); end
    n_checks++; if (addr[15:8] !== 8'h00 || wr_active[1] !== 1'b0) begin n_fail++; $display("FAIL ch1_idle got addr=%h wr=%b exp addr=00 wr=0", addr[15:8], wr_active[1]); end
  endtask

  task automatic test_priority;
    sr = 16'h4000; ld_n = 2'b01; cl_n = 2'b01;
    step(1);
    n_checks++; if (addr[15:8] !== 8'h40) begin n_fail++; $display("FAIL prio_addr got=%h exp=%h", addr[15:8], 8'h40); end
    n_checks++; if (wr_active[1] !== 1'b1 || win_left[15:8] !== 8'd16) begin n_fail++; $display("FAIL prio_win got wr=%b win=%0d exp wr=1 win=16", wr_active[1], win_left[15:8]); end
    ld_n = 2'b11;
    step(1);
    n_checks++; if (addr[15:8] !== 8'h00) begin n_fail++; $display("FAIL clr_addr got=%h exp=%h", addr[15:8], 8'h00); end
    n_checks++; if (wr_active[1] !== 1'b0 || win_left[15:8] !== 8'd0) begin n_fail++; $display("FAIL clr_win got wr=%b win=%0d exp wr=0 win=0", wr_active[1], win_left[15:8]); end
  endtask

  task automatic test_flip;
    logic [7:0] exp_a [3];
`ifdef MO_HFLIP_EN
    exp_a[0] = 8'h01; exp_a[1] = 8'h00; exp_a[2] = 8'hFF;
`else
    exp_a[0] = 8'h03; exp_a[1] = 8'h04; exp_a[2] = 8'h05;
`endif
    sr = 16'h0200; ld_n = 2'b10; cl_n = 2'b01; flip = 2'b01;
    step(1);
    n_checks++; if (addr[7:0] !== 8'h02) begin n_fail++; $display("FAIL flip_load got=%h exp=%h", addr[7:0], 8'h02); end
    ld_n = 2'b11;
    for (int i = 0; i < 3; i++) begin
      step(1);
      n_checks++; if (addr[7:0] !== exp_a[i]) begin n_fail++; $display("FAIL flip_count%0d got=%h exp=%h", i, addr[7:0], exp_a[i]); end
      n_checks++; if (win_left[7:0] !== 8'(15 - i)) begin n_fail++; $display("FAIL flip_win%0d got=%0d exp=%0d", i, win_left[7:0], 15 - i); end
    end
    flip = 2'b00;
  endtask

  task automatic test_ce_restart;
    sr = 16'h1000; ld_n = 2'b10; cl_n = 2'b01; flip = 2'b00;
    step(1);
    ld_n = 2'b11;
    step(5);
    n_checks++; if (addr[7:0] !== 8'h15 || win_left[7:0] !== 8'd11) begin n_fail++; $display("FAIL pre_gate got addr=%h win=%0d exp addr=15 win=11", addr[7:0], win_left[7:0]); end
    ce = 1'b0; ld_n = 2'b00; cl_n = 2'b00; sr = 16'hAA00;
    step(10);
    n_checks++; if (addr[7:0] !== 8'h15) begin n_fail++; $display("FAIL gate_addr got=%h exp=%h", addr[7:0], 8'h15); end
    n_checks++; if (win_left[7:0] !== 8'd11 || wr_active[0] !== 1'b1) begin n_fail++; $display("FAIL gate_win got win=%0d wr=%b exp win=11 wr=1", win_left[7:0], wr_active[0]); end
    ce = 1'b1; ld_n = 2'b11; cl_n = 2'b01;
    step(8);
    n_checks++; if (addr[7:0] !== 8'h1D || win_left[7:0] !== 8'd3) begin n_fail++; $display("FAIL pre_reload got addr=%h win=%0d exp addr=1D win=3", addr[7:0], win_left[7:0]); end
    sr = 16'h8000; ld_n = 2'b10;
    step(1);
    n_checks++; if (addr[7:0] !== 8'h80) begin n_fail++; $display("FAIL reload_addr got=%h exp=%h", addr[7:0], 8'h80); end
    n_checks++; if (win_left[7:0] !== 8'd16 || wr_active[0] !== 1'b1) begin n_fail++; $display("FAIL reload_win got win=%0d wr=%b exp win=16 wr=1", win_left[7:0], wr_active[0]); end
    ld_n = 2'b11;
  endtask

  task automatic test_back_to_back;
    // ch1 loads while ch0 keeps counting its window from the previous reload
    sr = 16'h2000; ld_n = 2'b01; cl_n = 2'b11;
    step(1);
    n_checks++; if (addr !== 16'h2081) begin n_fail++; $display("FAIL b2b_addr got=%h exp=%h", addr, 16'h2081); end
    n_checks++; if (win_left !== 16'h100F) begin n_fail++; $display("FAIL b2b_win got=%h exp=%h", win_left, 16'h100F); end
    sr = 16'h3000; ld_n = 2'b01;
    step(1);
    n_checks++; if (addr !== 16'h3082 || win_left !== 16'h100E) begin n_fail++; $display("FAIL b2b_reload got addr=%h win=%h exp addr=3082 win=100E", addr, win_left); end
    ld_n = 2'b11;
  endtask

  initial begin
    test_reset();
    test_load_count();
    test_priority();
    test_flip();
    test_ce_restart();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
